// File: rtl/dither_ordered_pkg.sv
// Shared definitions for the ordered-dither stage: mode codes and Bayer rank tables.
package dither_ordered_pkg;

    localparam logic [1:0] DITHER_TRUNC    = 2'd0;
    localparam logic [1:0] DITHER_STATIC   = 2'd1;
    localparam logic [1:0] DITHER_TEMPORAL = 2'd2;

    // Ranks indexed by {y, x}.
    localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2,
                                          2'd3, 2'd1};

    localparam logic [3:0] BAYER4 [16] = '{4'd0,  4'd8,  4'd2,  4'd10,
                                           4'd12, 4'd4,  4'd14, 4'd6,
                                           4'd3,  4'd11, 4'd1,  4'd9,
                                           4'd15, 4'd7,  4'd13, 4'd5};

endpackage

// File: rtl/dither_ordered_channel.sv
// Combinational per-channel reduction: truncate, or add threshold, shift and saturate.
module dither_ordered_channel
    import dither_ordered_pkg::*;
#(
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 1,
    parameter int T_BITS   = ((IN_BITS - OUT_BITS) > 0) ? (IN_BITS - OUT_BITS) : 1
) (
    input  logic [IN_BITS-1:0]  v_in,
    input  logic [T_BITS-1:0]   t,
    input  logic [1:0]          mode,
    output logic [OUT_BITS-1:0] v_out
);

    localparam int E_BITS = IN_BITS - OUT_BITS;

    generate
        if (E_BITS == 0) begin : g_pass
            assign v_out = v_in;
        end else begin : g_dither
            logic [IN_BITS:0] sum;
            logic [IN_BITS:0] shifted;

            // Sum carries one extra bit so the all-ones + threshold case saturates instead of wrapping.
            always_comb begin
                sum     = {1'b0, v_in} + {{(IN_BITS + 1 - T_BITS){1'b0}}, t};
                shifted = sum >> E_BITS;
                if (mode == DITHER_TRUNC) begin
                    v_out = v_in[IN_BITS-1:E_BITS];
                end else if (|shifted[IN_BITS:OUT_BITS]) begin
                    v_out = '1;
                end else begin
                    v_out = shifted[OUT_BITS-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dither_ordered.sv
// Ordered-dither output stage: frame tracking, rank lookup and a two-stage pipeline
// that carries colour, valid and syncs with identical latency.
module dither_ordered
    import dither_ordered_pkg::*;
#(
    parameter int IN_BITS     = 2,
    parameter int OUT_BITS    = 1,
    parameter int CHANNELS    = 3,
    parameter int MATRIX_LOG2 = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     mode,
    input  logic                           vsync_n_in,
    input  logic                           hsync_n_in,
    input  logic                           in_valid,
    input  logic [MATRIX_LOG2-1:0]         x_lsb,
    input  logic [MATRIX_LOG2-1:0]         y_lsb,
    input  logic [CHANNELS*IN_BITS-1:0]    rgb_in,
    output logic [CHANNELS*OUT_BITS-1:0]   rgb_out,
    output logic                           out_valid,
    output logic                           hsync_n_out,
    output logic                           vsync_n_out
);

    localparam int E_BITS = IN_BITS - OUT_BITS;
    localparam int R_BITS = 2 * MATRIX_LOG2;
    localparam int T_BITS = (E_BITS > 0) ? E_BITS : 1;
    localparam int IN_W   = CHANNELS * IN_BITS;
    localparam int OUT_W  = CHANNELS * OUT_BITS;

    logic              vsync_s1;
    logic              hsync_s1;
    logic              valid_s1;
    logic [IN_W-1:0]   rgb_s1;
    logic [T_BITS-1:0] t_s1;
    logic [1:0]        mode_s1;

    logic [R_BITS-1:0] frame_ctr;
    logic [1:0]        mode_active;
    logic              frame_edge;
    logic [R_BITS-1:0] rank;
    logic [R_BITS-1:0] rank_p;
    logic [T_BITS-1:0] t_next;
    logic [OUT_W-1:0]  dith;

    // The stage-1 vsync register doubles as the edge-detect history; the end of the pulse marks a new frame.
    assign frame_edge = ~vsync_s1 & vsync_n_in;

    generate
        if (MATRIX_LOG2 == 1) begin : g_rank2
            assign rank = BAYER2[{y_lsb, x_lsb}];
        end else begin : g_rank4
            assign rank = BAYER4[{y_lsb, x_lsb}];
        end
    endgenerate

    assign rank_p = (mode_active == DITHER_TEMPORAL) ? (rank + frame_ctr) : rank;

    // Threshold keeps the top E bits of the rank, or pads it up when the matrix is coarser than E.
    generate
        if (E_BITS == 0) begin : g_t_none
            assign t_next = '0;
        end else if (R_BITS >= E_BITS) begin : g_t_shr
            assign t_next = rank_p[R_BITS-1 -: E_BITS];
        end else begin : g_t_shl
            assign t_next = {rank_p, {(E_BITS - R_BITS){1'b0}}};
        end
    endgenerate

    // Frame counter and mode shadow only move on a frame edge, so a mode change never lands mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_ctr   <= '0;
            mode_active <= DITHER_TRUNC;
        end else if (frame_edge) begin
            frame_ctr   <= frame_ctr + R_BITS'(1);
            mode_active <= (mode == 2'd3) ? DITHER_STATIC : mode;
        end
    end

    // Stage 1: capture pixel, threshold, mode and syncs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_s1 <= 1'b1;
            hsync_s1 <= 1'b1;
            valid_s1 <= 1'b0;
            rgb_s1   <= '0;
            t_s1     <= '0;
            mode_s1  <= DITHER_TRUNC;
        end else begin
            vsync_s1 <= vsync_n_in;
            hsync_s1 <= hsync_n_in;
            valid_s1 <= in_valid;
            rgb_s1   <= rgb_in;
            t_s1     <= t_next;
            mode_s1  <= mode_active;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            dither_ordered_channel #(
                .IN_BITS  (IN_BITS),
                .OUT_BITS (OUT_BITS),
                .T_BITS   (T_BITS)
            ) u_channel (
                .v_in  (rgb_s1[c*IN_BITS +: IN_BITS]),
                .t     (t_s1),
                .mode  (mode_s1),
                .v_out (dith[c*OUT_BITS +: OUT_BITS])
            );
        end
    endgenerate

    // Stage 2: register dithered colour, forcing black outside the visible area.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out     <= '0;
            out_valid   <= 1'b0;
            hsync_n_out <= 1'b1;
            vsync_n_out <= 1'b1;
        end else begin
            rgb_out     <= valid_s1 ? dith : '0;
            out_valid   <= valid_s1;
            hsync_n_out <= hsync_s1;
            vsync_n_out <= vsync_s1;
        end
    end

endmodule

// File: tb/tb_dither_ordered.sv
// Directed bench for dither_ordered: default 2x2 instance plus a 4x4, 4-to-2 bit instance.
module tb_dither_ordered;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       vsync_n_in = 1'b1;
    logic       hsync_n_in = 1'b1;
    logic       in_valid = 1'b1;
    logic       x_lsb = 1'b0;
    logic       y_lsb = 1'b0;
    logic [5:0] rgb_in = 6'd0;
    logic [2:0] rgb_out;
    logic       out_valid;
    logic       hsync_n_out;
    logic       vsync_n_out;

    logic [1:0] x4 = 2'd0;
    logic [1:0] y4 = 2'd0;
    logic [3:0] rgb4_in = 4'd0;
    logic [1:0] rgb4_out;
    logic       valid4_out;
    logic       hsync4_out;
    logic       vsync4_out;

    int checks = 0;
    int errors = 0;
    int fc = 0;

    always #5 clk = ~clk;

    dither_ordered u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .vsync_n_in  (vsync_n_in),
        .hsync_n_in  (hsync_n_in),
        .in_valid    (in_valid),
        .x_lsb       (x_lsb),
        .y_lsb       (y_lsb),
        .rgb_in      (rgb_in),
        .rgb_out     (rgb_out),
        .out_valid   (out_valid),
        .hsync_n_out (hsync_n_out),
        .vsync_n_out (vsync_n_out)
    );

    dither_ordered #(
        .IN_BITS     (4),
        .OUT_BITS    (2),
        .CHANNELS    (1),
        .MATRIX_LOG2 (2)
    ) u_dut4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .vsync_n_in  (vsync_n_in),
        .hsync_n_in  (hsync_n_in),
        .in_valid    (in_valid),
        .x_lsb       (x4),
        .y_lsb       (y4),
        .rgb_in      (rgb4_in),
        .rgb_out     (rgb4_out),
        .out_valid   (valid4_out),
        .hsync_n_out (hsync4_out),
        .vsync_n_out (vsync4_out)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle vsync pulse; the frame edge is registered by the end of the second cycle.
    task automatic vsync_pulse();
        vsync_n_in = 1'b0;
        tick();
        vsync_n_in = 1'b1;
        tick();
        fc = (fc + 1) % 4;
    endtask

    logic       xs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       ys [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] exp_static [4] = '{3'b000, 3'b111, 3'b111, 3'b000};

    initial begin
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            rgb_in     = 6'($urandom);
            in_valid   = 1'($urandom);
            hsync_n_in = 1'($urandom);
            vsync_n_in = 1'($urandom);
            mode       = 2'($urandom);
            tick();
        end
        check("rst_rgb", {5'd0, rgb_out}, 8'd0);
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        check("rst_hsync", {7'd0, hsync_n_out}, 8'd1);
        check("rst_vsync", {7'd0, vsync_n_out}, 8'd1);
        check("rst_rgb4", {6'd0, rgb4_out}, 8'd0);

        // Release; mode input says static but truncate stays active until a frame edge.
        vsync_n_in = 1'b1;
        hsync_n_in = 1'b1;
        in_valid   = 1'b1;
        mode       = 2'd1;
        reset_n    = 1'b1;
        fc         = 0;
        x_lsb = 1'b1; y_lsb = 1'b0; rgb_in = 6'b01_01_01;
        tick(); tick();
        check("post_rst_trunc", {5'd0, rgb_out}, 8'b000);
        check("post_rst_valid", {7'd0, out_valid}, 8'd1);

        // Static 2x2, one pixel per cycle, each result two clocks later.
        vsync_pulse();
        rgb_in = 6'b01_01_01;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                x_lsb = xs[i];
                y_lsb = ys[i];
            end
            tick();
            if (i >= 1) check("static_0101", {5'd0, rgb_out}, {5'd0, exp_static[i-1]});
        end
        rgb_in = 6'b10_10_10;
        for (int i = 0; i < 4; i++) begin
            x_lsb = xs[i];
            y_lsb = ys[i];
            tick(); tick();
            check("static_1010", {5'd0, rgb_out}, 8'b111);
        end
        // All-ones at rank 2 (t=1) saturates instead of wrapping.
        rgb_in = 6'b11_11_11; x_lsb = 1'b1; y_lsb = 1'b0;
        tick(); tick();
        check("static_sat", {5'd0, rgb_out}, 8'b111);
        // Mode 3 behaves as static.
        mode = 2'd3;
        vsync_pulse();
        rgb_in = 6'b01_01_01; x_lsb = 1'b1; y_lsb = 1'b0;
        tick(); tick();
        check("mode3_static", {5'd0, rgb_out}, 8'b111);

        // Truncate: B=10 G=01 R=11 -> 1 0 1.
        mode = 2'd0;
        vsync_pulse();
        rgb_in = 6'b10_01_11; x_lsb = 1'b1; y_lsb = 1'b0;
        tick(); tick();
        check("trunc", {5'd0, rgb_out}, 8'b101);

        // Mid-frame switch to static stays truncated until the next frame edge.
        mode = 2'd1;
        rgb_in = 6'b01_01_01; x_lsb = 1'b1; y_lsb = 1'b0;
        tick(); tick();
        check("midframe_hold", {5'd0, rgb_out}, 8'b000);
        tick(); tick();
        check("midframe_hold2", {5'd0, rgb_out}, 8'b000);
        vsync_pulse();
        tick(); tick();
        check("midframe_apply", {5'd0, rgb_out}, 8'b111);

        // Temporal at (0,0): rank'=frame_ctr, t=rank'>>1, (1+t)>>1 = t. Eight frames covers the wrap.
        mode = 2'd2;
        x_lsb = 1'b0; y_lsb = 1'b0; rgb_in = 6'b01_01_01;
        for (int f = 0; f < 8; f++) begin
            vsync_pulse();
            tick(); tick();
            check("temporal", {5'd0, rgb_out}, (fc >= 2) ? 8'b111 : 8'b000);
        end

        // Blanking.
        in_valid = 1'b0; rgb_in = 6'b11_11_11;
        tick(); tick();
        check("blank_rgb", {5'd0, rgb_out}, 8'd0);
        check("blank_valid", {7'd0, out_valid}, 8'd0);

        // Sync pulses reappear exactly two clocks later.
        hsync_n_in = 1'b0;
        tick();
        check("hsync_d1", {7'd0, hsync_n_out}, 8'd1);
        hsync_n_in = 1'b1;
        tick();
        check("hsync_d2", {7'd0, hsync_n_out}, 8'd0);
        tick();
        check("hsync_d3", {7'd0, hsync_n_out}, 8'd1);
        vsync_n_in = 1'b0;
        tick();
        check("vsync_d1", {7'd0, vsync_n_out}, 8'd1);
        vsync_n_in = 1'b1;
        tick();
        check("vsync_d2", {7'd0, vsync_n_out}, 8'd0);
        tick();
        check("vsync_d3", {7'd0, vsync_n_out}, 8'd1);

        // 4x4, 4->2 bits, static: t = rank>>2.
        in_valid = 1'b1;
        mode = 2'd1;
        vsync_pulse();
        rgb4_in = 4'b0110; x4 = 2'd0; y4 = 2'd0;
        tick(); tick();
        check("b4_r0", {6'd0, rgb4_out}, 8'b01);
        x4 = 2'd1; y4 = 2'd0;
        tick(); tick();
        check("b4_r8", {6'd0, rgb4_out}, 8'b10);
        x4 = 2'd0; y4 = 2'd1;
        tick(); tick();
        check("b4_r12", {6'd0, rgb4_out}, 8'b10);
        x4 = 2'd2; y4 = 2'd2;
        tick(); tick();
        check("b4_r1", {6'd0, rgb4_out}, 8'b01);
        rgb4_in = 4'b1111; x4 = 2'd0; y4 = 2'd3;
        tick(); tick();
        check("b4_sat", {6'd0, rgb4_out}, 8'b11);

        // Reset mid-frame clears immediately; truncate until next frame edge.
        rgb_in = 6'b11_11_11; x_lsb = 1'b1; y_lsb = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check("midrst_rgb", {5'd0, rgb_out}, 8'd0);
        check("midrst_valid", {7'd0, out_valid}, 8'd0);
        tick();
        rgb_in = 6'b01_01_01;
        reset_n = 1'b1;
        fc = 0;
        tick(); tick();
        check("midrst_trunc", {5'd0, rgb_out}, 8'b000);
        vsync_pulse();
        tick(); tick();
        check("midrst_static", {5'd0, rgb_out}, 8'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
